// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state type and opcode class helper shared by seq_alu and muldiv_iter
package alu_pkg;
  localparam int ALU_CTRL_WIDTH = 5;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND   = 5'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR    = 5'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD   = 5'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB   = 5'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_NOR   = 5'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLT   = 5'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLTU  = 5'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR   = 5'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL   = 5'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRL   = 5'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRA   = 5'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_JAL   = 5'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL   = 5'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULH  = 5'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULHU = 5'd14;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_DIV   = 5'd15;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_DIVU  = 5'd16;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_REM   = 5'd17;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_REMU  = 5'd18;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic logic is_iterative(input logic [ALU_CTRL_WIDTH-1:0] op);
    return op >= OP_MUL && op <= OP_REMU;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier / restoring divider on operand magnitudes, sign fixed at the end
//   ports: clk, rst_n; start latches op/a/b; done pulses on the last step with result valid in that cycle
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ALU_CTRL_WIDTH-1:0] op,
  input  logic [W-1:0]              a,
  input  logic [W-1:0]              b,
  output logic                      done,
  output logic [W-1:0]              result
);
  localparam int CW = $clog2(W);
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, qr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, neg_q, neg_d, sgn_op, sa, sb, is_div;
  logic [ALU_CTRL_WIDTH-1:0] op_q, op_d;
  logic [W:0] sum, shifted, rem_try;
  logic [2*W-1:0] prod;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      neg_q <= 1'b0;
      op_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      neg_q <= neg_d;
      op_q <= op_d;
    end
  always_comb begin
    sgn_op = op == OP_MULH || op == OP_DIV || op == OP_REM;
    sa = sgn_op & a[W-1];
    sb = sgn_op & b[W-1];
    is_div = op_q >= OP_DIV;
    // multiply: hi accumulates B-magnitude whenever the next multiplier bit (lo[0]) is set
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
    shifted = {hi_q, lo_q[W-1]};
    rem_try = shifted - {1'b0, b_q};
    hi_d = hi_q;
    lo_d = lo_q;
    b_d = b_q;
    cnt_d = cnt_q;
    run_d = run_q;
    neg_d = neg_q;
    op_d = op_q;
    done = 1'b0;
    if (start) begin
      hi_d = '0;
      lo_d = sa ? -a : a;
      b_d = sb ? -b : b;
      cnt_d = '0;
      run_d = 1'b1;
      neg_d = op == OP_REM ? sa : sa ^ sb;
      op_d = op;
    end else if (run_q) begin
      if (is_div) begin
        hi_d = rem_try[W] ? shifted[W-1:0] : rem_try[W-1:0];
        lo_d = {lo_q[W-2:0], !rem_try[W]};
      end else
        {hi_d, lo_d} = {sum, lo_q[W-1:1]};
      cnt_d = cnt_q + CW'(1);
      done = cnt_q == CW'(W - 1);
      run_d = !done;
    end
    // result is taken from the post-step values so the last step and the load share one edge
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    qr = op_q == OP_REM || op_q == OP_REMU ? hi_d : lo_d;
    result = is_div ? (neg_q ? -qr : qr) : (op_q == OP_MUL ? prod[W-1:0] : prod[2*W-1:W]);
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle EX-stage ALU with valid/ready handshake, registered result, zero and illegal flags
//   ports: clk, rst_n (async, active-low), flush; in_valid/in_ready, alu_control, input_data_1/2, pc;
//          out_valid/out_ready, output_data, zero, illegal
//   SEQ_ALU_MULDIV_EN: enables MUL/MULH/MULHU/DIV/DIVU/REM/REMU via muldiv_iter; otherwise they are illegal
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control,
  input  logic [DATA_WIDTH-1:0]     input_data_1,
  input  logic [DATA_WIDTH-1:0]     input_data_2,
  input  logic [ADDR_WIDTH-1:0]     pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     output_data,
  output logic                      zero,
  output logic                      illegal
);
  localparam int SW = $clog2(DATA_WIDTH);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, res, a, b;
  logic [ADDR_WIDTH-1:0] pc4;
  logic [SW-1:0] shamt;
  logic zero_q, zero_d, ill_q, ill_d, ill, accept, iter_go;
  assign a = input_data_1;
  assign b = input_data_2;
  assign shamt = b[SW-1:0];
  assign pc4 = pc + ADDR_WIDTH'(4);
  assign accept = in_valid && in_ready;
`ifdef SEQ_ALU_MULDIV_EN
  logic md_done, div0, ovf;
  logic [DATA_WIDTH-1:0] md_res;
  assign div0 = b == '0;
  assign ovf = (alu_control == OP_DIV || alu_control == OP_REM) && a == {1'b1, {(DATA_WIDTH-1){1'b0}}} && b == '1;
  // divide by zero and signed overflow resolve in the single-cycle path
  assign iter_go = is_iterative(alu_control) && !(alu_control >= OP_DIV && (div0 || ovf));
  muldiv_iter #(.W(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_go && !flush),
    .op     (alu_control),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_res)
  );
`else
  assign iter_go = 1'b0;
`endif
  always_comb begin
    res = '0;
    ill = 1'b0;
    case (alu_control)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_NOR:  res = ~(a | b);
      OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, a < b};
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $signed(a) >>> shamt;
      OP_JAL:  res = DATA_WIDTH'(pc4);
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL, OP_MULH, OP_MULHU: res = '0;
      OP_DIV, OP_DIVU: res = div0 ? '1 : a;
      OP_REM, OP_REMU: res = div0 ? a : '0;
`endif
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      zero_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      zero_q <= zero_d;
      ill_q <= ill_d;
    end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    zero_d = zero_q;
    ill_d = ill_q;
    if (flush)
      state_d = IDLE;
    else if (accept && iter_go)
      state_d = BUSY;
    else if (accept) begin
      state_d = DONE;
      data_d = res;
      zero_d = alu_control == OP_JAL || res == '0;
      ill_d = ill;
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if (state_q == BUSY && md_done) begin
      state_d = DONE;
      data_d = md_res;
      zero_d = md_res == '0;
      ill_d = 1'b0;
    end
`endif
    else if (state_q == DONE && out_ready)
      state_d = IDLE;
  end
  always_comb begin
    in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    out_valid = state_q == DONE;
  end
  assign output_data = data_q;
  assign zero = zero_q;
  assign illegal = ill_q;
endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised execute-stage ALU. It replaces the single-cycle combinational ALU in the EX stage. It accepts one operation per valid/ready handshake and returns a registered result with a zero flag. Logic, shift, compare and add ops complete in one cycle. Multiply and divide (RV32M subset) run on an iterative radix-2 datapath. The block sits between the ID/EX operand latch and the EX/MEM register; the pipeline controller stalls on `in_ready`/`out_valid`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand and result width; must be a power of two, ≥ 8.
- `ADDR_WIDTH`, 32, PC width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: abort any in-flight op (branch mispredict or trap).
- `in_valid` in 1: operands and control valid.
- `in_ready` out 1: block can accept.
- `alu_control` in `ALU_CTRL_WIDTH` (5): opcode from `alu_pkg`.
- `input_data_1`, `input_data_2` in `DATA_WIDTH`: operands A and B.
- `pc` in `ADDR_WIDTH`: PC of the op; used by JAL only.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `output_data` out `DATA_WIDTH`: registered result.
- `zero` out 1: registered flag; 1 if `output_data`==0, forced to 1 for JAL.
- `illegal` out 1: registered flag; undefined or disabled opcode.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: iterative op running.
  - DONE: `out_valid`=1.
- `in_ready` = IDLE | (DONE & `out_ready`), so a new op can be accepted in the same cycle a result is retired.
- Accept (`in_valid` & `in_ready`), single-cycle opcode: compute, register the result, go to DONE.
- Accept, iterative opcode: latch operands, counter := 0, go to BUSY.
- BUSY: one quotient or partial-product bit per cycle. Counter reaching `DATA_WIDTH`-1 loads the result and goes to DONE.
- DONE & `out_ready` & no new accept: go to IDLE.
- DONE & !`out_ready`: hold `output_data`, `zero` and `illegal` stable.
- Opcodes:
  - AND, OR, XOR, NOR.
  - ADD, SUB: wrap modulo 2^`DATA_WIDTH`.
  - SLT: signed A<B → 1, else 0.
  - SLTU: the unsigned form of SLT.
  - SLL, SRL, SRA: shift amount = B[log2(`DATA_WIDTH`)-1:0], upper bits ignored.
  - JAL: `pc`+4, zero-extended or truncated to `DATA_WIDTH`.
  - MUL: low half of the product.
  - MULH: signed high half. MULHU: unsigned high half.
  - DIV, DIVU, REM, REMU: truncating division; remainder sign follows the dividend.
- Signed multiply/divide: operate on magnitudes, then negate the result by sign rule.
- Divide special cases:
  - Divisor 0: quotient all-ones, remainder = A. Completes in one cycle (no BUSY).
  - Signed overflow (A = most-negative, B = −1): quotient = A, remainder 0. Completes in one cycle.
- Undefined opcode: result 0, `illegal`=1, one cycle.
- `flush`: from any state, go to IDLE next edge. No `out_valid` is produced for the flushed op. `flush` takes priority over a same-cycle accept; that op is dropped.

## Timing
- Reset values: state IDLE, `out_valid` 0, `output_data` 0, `zero` 0, `illegal` 0, counter 0. `in_ready` reads 1 while in reset-IDLE.
- Single-cycle ops and divide special cases: `out_valid` rises the edge after accept (latency 1).
- Iterative ops: `out_valid` rises `DATA_WIDTH`+1 edges after accept (33 at default).
- Back-to-back single-cycle ops with `out_ready` held high: one result per cycle.
- `rst_n` low mid-BUSY: asynchronous return to reset values; the partial result is discarded.

## Configuration
- `SEQ_ALU_MULDIV_EN` defined: MUL/MULH/MULHU/DIV/DIVU/REM/REMU supported, iterative sub-module instantiated, BUSY reachable.
- `SEQ_ALU_MULDIV_EN` undefined: those opcodes take the undefined-opcode path (result 0, `illegal`=1, latency 1). No sub-module and no BUSY state logic.

## Structure
- `alu_pkg` holds:
  - `ALU_CTRL_WIDTH`=5.
  - Opcode constants: AND 0, OR 1, ADD 2, SUB 3, NOR 4, SLT 5, SLTU 6, XOR 7, SLL 8, SRL 9, SRA 10, JAL 11, MUL 12, MULH 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18.
  - State enum: IDLE, BUSY, DONE.
  - Helper `is_iterative(op)`.
- One sub-module, `muldiv_iter`: shared shift-add / shift-subtract datapath. Interface: start, op, A, B, done, result.

## Test plan
- ADD 5+7, `out_ready`=1 → `out_valid` on the next cycle, `output_data`=12, `zero`=0. SUB 7−7 → 0, `zero`=1.
- SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0. SRA 0x80000000 by 0x21 → 0xC0000000 (shift amount 1).
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE after exactly 33 cycles. MUL the same operands → 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same → 0. DIVU 9/0 → 0xFFFFFFFF. Division-by-zero and overflow cases complete with latency 1.
- DIVU issued, `flush` at cycle 10 → no `out_valid` ever; `in_ready`=1 on the next cycle; following ADD 1+1 returns 2.
- `out_ready`=0 for 5 cycles in DONE → output stable, `in_ready`=0. Opcode 31 → `illegal`=1, result 0. JAL with `pc`=0x100 → 0x104, `zero`=1.
